wwdt_refresh_ctrl: RTL and testbench
====================================

// Module: wwdt_refresh_ctrl
// PURPOSE
//  APB master that configures and services the 7-bit window watchdog (wdt) slave.
//  On start it writes the compare window (CFR) and then enables the counter (CR).
//  It then polls CR and rewrites the reload value before the count reaches the window.
//  A software kick forces an early refresh, stop disables the watchdog, and a
//  wdt_intr assertion is latched as a sticky fault. Sits between the system
//  controller and the wdt APB port.
// PARAMETERS
//  RELOAD    7'h7F   count written to CR[6:0] on enable/refresh
//  WINDOW    7'h40   value written to CFR[6:0]; wdt fires when count <= WINDOW
//  GUARD     4       refresh when polled count <= WINDOW+GUARD (8-bit sum)
//  POLL_GAP  8       idle cycles between polls (>=1)
//  ADDR_CR   32'h0   CR address;   ADDR_CFR 32'h1   CFR address
//  Legal only if WINDOW+GUARD < RELOAD; elaboration error otherwise.
// PORTS
//  pclk        in   1   clock
//  prst        in   1   async reset, active-high
//  start       in   1   pulse: configure+enable (ignored while active)
//  stop        in   1   pulse: disable watchdog, return to IDLE
//  kick        in   1   pulse: request an immediate refresh while active
//  wdt_intr    in   1   interrupt from wdt slave
//  psel        out  1   APB select
//  penable     out  1   APB enable
//  pwrite      out  1   APB direction (1=write)
//  paddr       out  32  APB address
//  pwdata      out  32  APB write data
//  prdata      in   32  APB read data (valid one cycle after access completes)
//  pready      in   1   APB ready
//  active      out  1   watchdog enabled and being serviced
//  err         out  1   sticky fault (wdt_intr seen while active)
//  last_cnt    out  7   count captured by most recent poll
//  refresh_cnt out  16  refreshes issued since start, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, gap counter 0; asserting prst mid-transfer drops psel/penable at once.
//  APB transfer = SETUP (psel=1,penable=0, 1 cycle) then ACCESS (psel=1,penable=1)
//   held until pready=1 is sampled. paddr/pwrite/pwdata stay stable SETUP..ACCESS end; psel=0 between transfers.
//  FSM: IDLE -start-> CFG (write CFR={25'b0,WINDOW}) -> EN (write CR={24'b0,1'b1,RELOAD});
//   active=1 after the EN access completes -> WAIT.
//  WAIT: count POLL_GAP cycles -> RD (read CR) -> CAP (one cycle, sample prdata:
//   last_cnt=prdata[6:0]). Then: prdata[7]==0 -> FAULT; cnt <= WINDOW+GUARD -> RF; else WAIT.
//  RF: write CR={24'b0,1'b1,RELOAD}, refresh_cnt+1 (saturating) on completion -> WAIT.
//  kick: latched (single pending flag, extra kicks merge); serviced as RF at next WAIT exit.
//  stop: latched; at next transfer boundary (never mid-transfer) write CR=32'h0,
//   active=0 -> IDLE. Priority at a boundary: stop > kick > poll.
//  wdt_intr=1 while active (any state): err=1, enter FAULT after the current transfer.
//  FAULT: no APB traffic, active=0, err held. start in FAULT or IDLE clears err,
//   refresh_cnt and last_cnt and re-runs CFG. stop in FAULT -> IDLE, err retained.
//  start while active: ignored. start and stop in same IDLE cycle: stop wins (stay IDLE).
// TESTING
//  1 prst=1 mid-ACCESS -> psel/penable/active/err drop to 0 same cycle, IDLE after release.
//  2 start, pready=1 always -> write 0x40 @1, write 0xFF @0, active=1; polls @0 every 8+4 cycles.
//  3 model returns counts 0x50, 0x45, 0x44 -> no refresh at 0x50/0x45, refresh at 0x44,
//    refresh_cnt=1, last_cnt=7'h44.
//  4 kick pulsed twice in WAIT -> exactly one CR=0xFF write before next poll.
//  5 pready held 0 for 5 cycles in RD with stop pulsed -> read completes, then CR=0x00 write, IDLE.
//  6 wdt_intr=1 while active -> err=1, active=0, no APB traffic; start -> err=0, CFG reissued.

Source files
------------

// File: rtl/wwdt_refresh_ctrl.sv
// APB master that configures, polls and refreshes a 7-bit window watchdog.
// Tracks kick/stop requests and latches a sticky fault on wdt interrupt.
module wwdt_refresh_ctrl #(
   parameter logic [6:0]  RELOAD   = 7'h7F,
   parameter logic [6:0]  WINDOW   = 7'h40,
   parameter int          GUARD    = 4,
   parameter int          POLL_GAP = 8,
   parameter logic [31:0] ADDR_CR  = 32'h0,
   parameter logic [31:0] ADDR_CFR = 32'h1
) (
   input  logic        pclk,
   input  logic        prst,
   input  logic        start,
   input  logic        stop,
   input  logic        kick,
   input  logic        wdt_intr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   output logic        active,
   output logic        err,
   output logic [6:0]  last_cnt,
   output logic [15:0] refresh_cnt
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_CFG   = 4'd1;
   localparam logic [3:0] S_EN    = 4'd2;
   localparam logic [3:0] S_WAIT  = 4'd3;
   localparam logic [3:0] S_RD    = 4'd4;
   localparam logic [3:0] S_CAP   = 4'd5;
   localparam logic [3:0] S_RF    = 4'd6;
   localparam logic [3:0] S_STOP  = 4'd7;
   localparam logic [3:0] S_FAULT = 4'd8;

   localparam logic [7:0] LIMIT = {1'b0, WINDOW} + 8'(GUARD);
   localparam logic [7:0] GAP   = 8'(POLL_GAP);

   if (LIMIT >= {1'b0, RELOAD}) begin : g_bad_cfg
      $error("wwdt_refresh_ctrl: WINDOW+GUARD must be below RELOAD");
   end

   logic [3:0]  r_state;
   logic [1:0]  r_ph;
   logic [7:0]  r_gap;
   logic        r_active;
   logic        r_err;
   logic        r_fpend;
   logic        r_stop;
   logic        r_kick;
   logic [6:0]  r_last;
   logic [15:0] r_cnt;

   logic [3:0]  w_nxt;
   logic [3:0]  w_bnd;
   logic        w_xfer;
   logic        w_done;
   logic        w_hold;
   logic        w_low;
   logic        w_busy;
   logic        w_start;
   logic        w_to_fault;
   logic        w_to_idle;
   logic        w_unused;

   assign w_xfer = (r_state == S_CFG) | (r_state == S_EN) | (r_state == S_RD)
                 | (r_state == S_RF)  | (r_state == S_STOP);
   assign psel    = w_xfer & (r_ph != 2'd0);
   assign penable = w_xfer & (r_ph == 2'd2);
   assign w_done  = penable & pready;
   assign pwrite  = w_xfer & (r_state != S_RD);
   assign paddr   = (w_xfer && r_state == S_CFG) ? ADDR_CFR :
                    (w_xfer ? ADDR_CR : 32'h0);

   always_comb begin
      pwdata = 32'h0;
      if (r_state == S_CFG)
         pwdata = {25'b0, WINDOW};
      else if (r_state == S_EN || r_state == S_RF)
         pwdata = {24'b0, 1'b1, RELOAD};
   end

   assign w_hold   = r_fpend | r_stop;
   assign w_low    = {1'b0, prdata[6:0]} <= LIMIT;
   assign w_busy   = (r_state != S_IDLE) & (r_state != S_FAULT)
                   & (r_state != S_STOP);
   assign w_unused = ^prdata[31:8];

   // Boundary priority: pending fault, then stop, then kick, else resume polling.
   always_comb begin
      w_bnd = S_WAIT;
      if (r_fpend)
         w_bnd = S_FAULT;
      else if (r_stop)
         w_bnd = S_STOP;
      else if (r_kick)
         w_bnd = S_RF;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE, S_FAULT: begin
            if (stop)
               w_nxt = S_IDLE;
            else if (start)
               w_nxt = S_CFG;
         end
         S_CFG:
            if (w_done) w_nxt = r_stop ? S_STOP : S_EN;
         S_EN:
            if (w_done) w_nxt = w_hold ? w_bnd : S_WAIT;
         S_WAIT: begin
            if (w_hold | r_kick)
               w_nxt = w_bnd;
            else if (r_gap >= GAP)
               w_nxt = S_RD;
         end
         S_RD:
            if (w_done) w_nxt = S_CAP;
         S_CAP: begin
            if (w_hold)
               w_nxt = w_bnd;
            else if (!prdata[7])
               w_nxt = S_FAULT;
            else if (r_kick | w_low)
               w_nxt = S_RF;
            else
               w_nxt = S_WAIT;
         end
         S_RF:
            if (w_done) w_nxt = w_hold ? w_bnd : S_WAIT;
         S_STOP:
            if (w_done) w_nxt = r_fpend ? S_FAULT : S_IDLE;
         default:
            w_nxt = S_IDLE;
      endcase
   end

   assign w_start    = ((r_state == S_IDLE) | (r_state == S_FAULT))
                     & (w_nxt == S_CFG);
   assign w_to_fault = (w_nxt == S_FAULT) & (r_state != S_FAULT);
   assign w_to_idle  = (w_nxt == S_IDLE);

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         r_state  <= S_IDLE;
         r_ph     <= 2'd0;
         r_gap    <= 8'd0;
         r_active <= 1'b0;
         r_err    <= 1'b0;
         r_fpend  <= 1'b0;
         r_stop   <= 1'b0;
         r_kick   <= 1'b0;
         r_last   <= 7'd0;
         r_cnt    <= 16'd0;
      end else begin
         r_state <= w_nxt;
         // A transfer entered straight from another leaves one idle psel=0 cycle.
         if (w_nxt != r_state)
            r_ph <= w_done ? 2'd0 : 2'd1;
         else if (w_xfer && r_ph != 2'd2)
            r_ph <= r_ph + 2'd1;

         r_gap <= (r_state == S_WAIT) ? r_gap + 8'd1 : 8'd0;

         if (r_state == S_EN && w_done)
            r_active <= 1'b1;
         if (w_to_fault || (r_state == S_STOP && w_done))
            r_active <= 1'b0;

         if (r_active && wdt_intr) begin
            r_err   <= 1'b1;
            r_fpend <= 1'b1;
         end
         if (w_to_fault)
            r_err <= 1'b1;
         if (w_start)
            r_err <= 1'b0;
         if (w_to_fault || w_start || w_to_idle)
            r_fpend <= 1'b0;

         if (stop && w_busy)
            r_stop <= 1'b1;
         if (w_nxt == S_STOP || w_to_idle || w_to_fault || w_start)
            r_stop <= 1'b0;

         if (kick && r_active && r_state != S_STOP)
            r_kick <= 1'b1;
         if ((r_state == S_RF && w_done) || w_nxt == S_STOP
             || w_to_idle || w_to_fault || w_start)
            r_kick <= 1'b0;

         if (w_start)
            r_last <= 7'd0;
         else if (r_state == S_CAP)
            r_last <= prdata[6:0];

         if (w_start)
            r_cnt <= 16'd0;
         else if (r_state == S_RF && w_done && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
      end
   end

   assign active      = r_active;
   assign err         = r_err;
   assign last_cnt    = r_last;
   assign refresh_cnt = r_cnt;

endmodule

// File: tb/tb_wwdt_refresh_ctrl.sv
// Directed bench for wwdt_refresh_ctrl: a logging APB monitor plus
// a linear sequence of steps checked with immediate assertions.
module tb_wwdt_refresh_ctrl;

   logic        pclk = 1'b0;
   logic        prst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        kick = 1'b0;
   logic        wdt_intr = 1'b0;
   logic        pready = 1'b1;
   logic [31:0] prdata = 32'h0;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        active;
   logic        err;
   logic [6:0]  last_cnt;
   logic [15:0] refresh_cnt;

   int          cyc = 0;
   int          n_xfer = 0;
   logic [31:0] xaddr[$];
   logic [31:0] xdata[$];
   logic        xwr[$];
   int          xcyc[$];
   int          nchk = 0;
   int          npass = 0;
   int          nfail = 0;
   int          period;

   wwdt_refresh_ctrl dut (
      .pclk(pclk),
      .prst(prst),
      .start(start),
      .stop(stop),
      .kick(kick),
      .wdt_intr(wdt_intr),
      .psel(psel),
      .penable(penable),
      .pwrite(pwrite),
      .paddr(paddr),
      .pwdata(pwdata),
      .prdata(prdata),
      .pready(pready),
      .active(active),
      .err(err),
      .last_cnt(last_cnt),
      .refresh_cnt(refresh_cnt)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk) begin
      cyc++;
      if (psel && penable && pready) begin
         xaddr.push_back(paddr);
         xdata.push_back(pwdata);
         xwr.push_back(pwrite);
         xcyc.push_back(cyc);
         n_xfer++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic wait_xfer(input int n);
      for (int i = 0; i < 100 && n_xfer < n; i++)
         @(negedge pclk);
      chk("xfer wait", 32'(n_xfer >= n), 32'd1);
   endtask

   initial begin
      #1 prst = 1'b1;
      cycles(1);
      chk("rst psel", psel, 0);
      chk("rst penable", penable, 0);
      chk("rst active", active, 0);
      chk("rst err", err, 0);
      chk("rst last_cnt", last_cnt, 0);
      chk("rst refresh_cnt", refresh_cnt, 0);
      prst = 1'b0;
      cycles(2);

      // reset in the middle of a stalled ACCESS
      pready = 1'b0;
      start = 1'b1;
      cycles(1);
      start = 1'b0;
      chk("cfg setup psel", psel, 1);
      chk("cfg setup penable", penable, 0);
      cycles(1);
      chk("cfg access penable", penable, 1);
      chk("cfg access paddr", paddr, 32'h1);
      #2 prst = 1'b1;
      #1;
      chk("midrst psel", psel, 0);
      chk("midrst penable", penable, 0);
      chk("midrst active", active, 0);
      chk("midrst err", err, 0);
      cycles(1);
      prst = 1'b0;
      pready = 1'b1;
      cycles(3);
      chk("post rst idle psel", psel, 0);
      chk("post rst no xfer", n_xfer, 0);

      // configure and enable
      prdata = 32'hD0;
      start = 1'b1;
      cycles(1);
      start = 1'b0;
      wait_xfer(2);
      chk("cfg addr", xaddr[0], 32'h1);
      chk("cfg data", xdata[0], 32'h40);
      chk("cfg write", xwr[0], 1);
      chk("en addr", xaddr[1], 32'h0);
      chk("en data", xdata[1], 32'hFF);
      chk("active after en", active, 1);

      // polls at 0x50, 0x45, 0x44
      wait_xfer(3);
      chk("poll0 read", xwr[2], 0);
      chk("poll0 addr", xaddr[2], 32'h0);
      cycles(1);
      chk("last 0x50", last_cnt, 7'h50);
      prdata = 32'hC5;
      wait_xfer(4);
      period = xcyc[3] - xcyc[2];
      chk("poll period", period, 12);
      chk("poll1 read", xwr[3], 0);
      cycles(1);
      chk("last 0x45", last_cnt, 7'h45);
      chk("no refresh yet", refresh_cnt, 0);
      prdata = 32'hC4;
      wait_xfer(5);
      chk("poll2 read", xwr[4], 0);
      cycles(1);
      chk("last 0x44", last_cnt, 7'h44);
      prdata = 32'hD0;
      wait_xfer(6);
      chk("refresh write", xwr[5], 1);
      chk("refresh addr", xaddr[5], 32'h0);
      chk("refresh data", xdata[5], 32'hFF);
      cycles(1);
      chk("refresh_cnt 1", refresh_cnt, 1);

      // two kicks merge into one refresh
      kick = 1'b1;
      cycles(1);
      kick = 1'b0;
      cycles(1);
      kick = 1'b1;
      cycles(1);
      kick = 1'b0;
      wait_xfer(8);
      chk("kick write", xwr[6], 1);
      chk("kick data", xdata[6], 32'hFF);
      chk("after kick is poll", xwr[7], 0);
      chk("refresh_cnt 2", refresh_cnt, 2);

      // stop during a stalled read
      pready = 1'b0;
      for (int i = 0; i < 40 && penable !== 1'b1; i++)
         cycles(1);
      chk("rd stall reached", penable, 1);
      chk("rd stall is read", pwrite, 0);
      stop = 1'b1;
      cycles(1);
      stop = 1'b0;
      cycles(4);
      chk("still stalled", n_xfer, 8);
      pready = 1'b1;
      wait_xfer(9);
      chk("stalled read done", xwr[8], 0);
      wait_xfer(10);
      chk("stop write", xwr[9], 1);
      chk("stop addr", xaddr[9], 32'h0);
      chk("stop data", xdata[9], 32'h0);
      cycles(1);
      chk("inactive after stop", active, 0);
      cycles(20);
      chk("idle no traffic", n_xfer, 10);

      // start and stop together in IDLE: stop wins
      start = 1'b1;
      stop = 1'b1;
      cycles(1);
      start = 1'b0;
      stop = 1'b0;
      cycles(5);
      chk("start+stop idle", n_xfer, 10);
      chk("start+stop psel", psel, 0);

      // wdt interrupt while active
      start = 1'b1;
      cycles(1);
      start = 1'b0;
      wait_xfer(12);
      cycles(1);
      chk("restart active", active, 1);
      chk("restart err", err, 0);
      wdt_intr = 1'b1;
      cycles(1);
      wdt_intr = 1'b0;
      cycles(1);
      chk("fault err", err, 1);
      chk("fault active", active, 0);
      chk("fault psel", psel, 0);
      cycles(20);
      chk("fault no traffic", n_xfer, 12);
      chk("fault err held", err, 1);
      start = 1'b1;
      cycles(1);
      start = 1'b0;
      chk("start clears err", err, 0);
      chk("start clears refresh_cnt", refresh_cnt, 0);
      wait_xfer(13);
      chk("cfg reissued addr", xaddr[12], 32'h1);
      chk("cfg reissued data", xdata[12], 32'h40);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
